// File: rtl/button_blip.sv
// Two-button input conditioner: 2-flop synchroniser, debounce FSM, and enable/conflict
// gated single-cycle press pulses. Define BUTTON_BLIP_AUTO_REPEAT_EN for hold-to-repeat.
module button_blip #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_RATE     = 10000000
) (
  input  logic Clk100M,
  input  logic reset,
  input  logic btnUpRaw,
  input  logic btnDownRaw,
  input  logic enable,
  output logic userUp,
  output logic userDown,
  output logic upHeld,
  output logic downHeld
);

  typedef enum logic [1:0] {IDLE, PRESS_CHK, PRESSED, REL_CHK} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_debounce
    $error("button_blip: DEBOUNCE_CYCLES out of range for CNT_W");
  end
  if (REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DELAY) begin : g_bad_repeat
    $error("button_blip: REPEAT_RATE must be in 1..REPEAT_DELAY");
  end

  logic [1:0] raw;
  logic [1:0] cand;
  logic [1:0] held;
  logic [1:0] pulse_reg;

  assign raw = {btnDownRaw, btnUpRaw};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic             sync1_reg;
      logic             sync2_reg;
      state_t           state_reg;
      state_t           state_next;
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;
      logic             press_cand;
      logic             rep_cand;
      logic             cand_reg;
      logic             held_reg;

      always_ff @(posedge Clk100M) begin
        if (reset) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= raw[gi];
          sync2_reg <= sync1_reg;
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
        end
      end

      // cnt holds the number of consecutive agreeing samples minus one while checking
      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        press_cand = 1'b0;
        case (state_reg)
          IDLE: begin
            if (sync2_reg) begin
              state_next = PRESS_CHK;
              cnt_next   = CNT_W'(1);
            end
          end
          PRESS_CHK: begin
            if (!sync2_reg) begin
              state_next = IDLE;
              cnt_next   = '0;
            end else if (cnt_reg == CNT_LAST) begin
              state_next = PRESSED;
              cnt_next   = '0;
              press_cand = 1'b1;
            end else begin
              cnt_next = cnt_reg + CNT_W'(1);
            end
          end
          PRESSED: begin
            if (!sync2_reg) begin
              state_next = REL_CHK;
              cnt_next   = CNT_W'(1);
            end
          end
          REL_CHK: begin
            if (sync2_reg) begin
              state_next = PRESSED;
              cnt_next   = '0;
            end else if (cnt_reg == CNT_LAST) begin
              state_next = IDLE;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg + CNT_W'(1);
            end
          end
          default: begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        endcase
      end

`ifdef BUTTON_BLIP_AUTO_REPEAT_EN
      localparam int REP_W = $clog2(REPEAT_DELAY + 1);
      localparam logic [REP_W-1:0] REP_LAST   = REP_W'(REPEAT_DELAY - 1);
      localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REPEAT_DELAY - REPEAT_RATE);
      logic [REP_W-1:0] rep_reg;

      // Runs only in PRESSED, frozen in REL_CHK, cleared once the press is fully released.
      // Reloading to DELAY-RATE makes later candidates arrive every REPEAT_RATE cycles.
      always_ff @(posedge Clk100M) begin
        if (reset || state_reg == IDLE || state_reg == PRESS_CHK) begin
          rep_reg <= '0;
        end else if (state_reg == PRESSED) begin
          if (rep_reg == REP_LAST) begin
            rep_reg <= REP_RELOAD;
          end else begin
            rep_reg <= rep_reg + REP_W'(1);
          end
        end
      end

      assign rep_cand = (state_reg == PRESSED) && (rep_reg == REP_LAST);
`else
      assign rep_cand = 1'b0;
`endif

      // Candidate and held are both registered so they line up with the pulse outputs
      always_ff @(posedge Clk100M) begin
        if (reset) begin
          cand_reg <= 1'b0;
          held_reg <= 1'b0;
        end else begin
          cand_reg <= press_cand | rep_cand;
          held_reg <= (state_reg == PRESSED) || (state_reg == REL_CHK);
        end
      end

      assign cand[gi] = cand_reg;
      assign held[gi] = held_reg;
    end
  endgenerate

  // Simultaneous up/down candidates cancel each other out
  always_ff @(posedge Clk100M) begin
    if (reset) begin
      pulse_reg <= 2'b00;
    end else begin
      pulse_reg[0] <= cand[0] & enable & ~cand[1];
      pulse_reg[1] <= cand[1] & enable & ~cand[0];
    end
  end

  assign userUp   = pulse_reg[0];
  assign userDown = pulse_reg[1];
  assign upHeld   = held[0];
  assign downHeld = held[1];

endmodule
